// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit and its prediction queue.
package branch_resolve_unit_pkg;

    // Default widths.
    localparam int unsigned PC_WIDTH_DEF  = 32;
    localparam int unsigned CNT_WIDTH_DEF = 32;
    localparam int unsigned DEPTH_DEF     = 4;

    // Fall-through distance for a not-taken branch.
    localparam int unsigned PC_INCR = 4;

    // Queue entry layout, LSB first: {pc, pred_taken}.
    localparam int unsigned ENTRY_PRED_BIT = 0;
    localparam int unsigned ENTRY_PC_LSB   = 1;

    // Entry layout at the default PC width.
    typedef struct packed {
        logic [PC_WIDTH_DEF-1:0] pc;
        logic                    pred_taken;
    } pred_entry_t;

    // Width of a packed queue entry for a given PC width.
    function automatic int unsigned entry_width(input int unsigned pc_width);
        return pc_width + 1;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_pred_fifo.sv
// In-order prediction queue: synchronous FIFO with a dominant clear.
// The head entry is readable combinationally.
module branch_resolve_unit_pred_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enq,
    input  logic [WIDTH-1:0] enq_data,
    input  logic             deq,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_enq;
    logic             do_deq;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign head_data = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a full queue can accept one push.
    assign do_deq = deq & ~empty;
    assign do_enq = enq & (~full | do_deq);

    // Next-state for pointers, occupancy and storage; clear wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_enq) begin
                mem_d[wr_ptr_q] = enq_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_deq) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_enq, do_deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Queue state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: queues IF-stage predictions, checks them against EX
// outcomes, updates the predictor, and flushes/redirects on a mispredict.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned PC_WIDTH  = PC_WIDTH_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 if_valid,
    input  logic                 if_is_br,
    input  logic [PC_WIDTH-1:0]  if_pc,
    input  logic                 if_pred_taken,
    output logic                 if_stall,
    input  logic                 ex_valid,
    input  logic                 ex_is_br,
    input  logic [PC_WIDTH-1:0]  ex_pc,
    input  logic                 ex_taken,
    input  logic [PC_WIDTH-1:0]  ex_target,
    output logic [PC_WIDTH-1:0]  pc_check,
    output logic                 is_br_check,
    output logic                 br_taken_check,
    output logic                 flush,
    output logic [PC_WIDTH-1:0]  redirect_pc,
    output logic                 order_err,
    output logic [CNT_WIDTH-1:0] br_count,
    output logic [CNT_WIDTH-1:0] mispred_count
);
    localparam int unsigned ENTRY_W = entry_width(PC_WIDTH);

    logic [ENTRY_W-1:0]   enq_entry;
    logic [ENTRY_W-1:0]   head_entry;
    logic [PC_WIDTH-1:0]  head_pc;
    logic                 head_pred;
    logic                 q_full;
    logic                 q_empty;
    logic                 enq;
    logic                 resolve;
    logic                 mispredict;
    logic                 pc_mismatch;

    logic [PC_WIDTH-1:0]  pc_check_q, pc_check_d;
    logic                 is_br_check_q, is_br_check_d;
    logic                 br_taken_check_q, br_taken_check_d;
    logic                 flush_q, flush_d;
    logic [PC_WIDTH-1:0]  redirect_pc_q, redirect_pc_d;
    logic                 order_err_q, order_err_d;
    logic [CNT_WIDTH-1:0] br_count_q, br_count_d;
    logic [CNT_WIDTH-1:0] mispred_count_q, mispred_count_d;

    assign resolve = ex_valid & ex_is_br;

    // Stall only when full and no pop frees a slot this cycle.
    assign if_stall = if_valid & if_is_br & q_full & ~resolve;

    // No new predictions are accepted while the flush is visible to IF.
    assign enq = if_valid & if_is_br & ~if_stall & ~flush_q;

    assign enq_entry = {if_pc, if_pred_taken};
    assign head_pc   = head_entry[ENTRY_PC_LSB +: PC_WIDTH];
    assign head_pred = head_entry[ENTRY_PRED_BIT];

    // Empty-queue resolve behaves as a not-taken prediction.
    always_comb begin
        mispredict  = 1'b0;
        pc_mismatch = 1'b0;
        if (resolve) begin
            if (q_empty) begin
                mispredict  = ex_taken;
                pc_mismatch = 1'b1;
            end else begin
                mispredict  = (head_pred != ex_taken);
                pc_mismatch = (head_pc != ex_pc);
            end
        end
    end

    branch_resolve_unit_pred_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_pred_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (mispredict),
        .enq       (enq),
        .enq_data  (enq_entry),
        .deq       (resolve),
        .head_data (head_entry),
        .full      (q_full),
        .empty     (q_empty)
    );

    // Next-state for predictor update, flush/redirect, error flag and counters.
    always_comb begin
        is_br_check_d    = resolve;
        pc_check_d       = resolve ? ex_pc : '0;
        br_taken_check_d = resolve & ex_taken;
        flush_d          = mispredict;
        redirect_pc_d    = redirect_pc_q;
        order_err_d      = order_err_q | pc_mismatch;
        br_count_d       = br_count_q;
        mispred_count_d  = mispred_count_q;
        if (mispredict) begin
            redirect_pc_d   = ex_taken ? ex_target : (ex_pc + PC_WIDTH'(PC_INCR));
            mispred_count_d = mispred_count_q + 1'b1;
        end
        if (resolve) begin
            br_count_d = br_count_q + 1'b1;
        end
    end

    // Output and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_check_q       <= '0;
            is_br_check_q    <= 1'b0;
            br_taken_check_q <= 1'b0;
            flush_q          <= 1'b0;
            redirect_pc_q    <= '0;
            order_err_q      <= 1'b0;
            br_count_q       <= '0;
            mispred_count_q  <= '0;
        end else begin
            pc_check_q       <= pc_check_d;
            is_br_check_q    <= is_br_check_d;
            br_taken_check_q <= br_taken_check_d;
            flush_q          <= flush_d;
            redirect_pc_q    <= redirect_pc_d;
            order_err_q      <= order_err_d;
            br_count_q       <= br_count_d;
            mispred_count_q  <= mispred_count_d;
        end
    end

    assign pc_check       = pc_check_q;
    assign is_br_check    = is_br_check_q;
    assign br_taken_check = br_taken_check_q;
    assign flush          = flush_q;
    assign redirect_pc    = redirect_pc_q;
    assign order_err      = order_err_q;
    assign br_count       = br_count_q;
    assign mispred_count  = mispred_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with hand-computed expectations.
module tb_branch_resolve_unit;
    localparam int PW = 32;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_valid, if_is_br, if_pred_taken;
    logic [PW-1:0] if_pc;
    logic          if_stall;
    logic          ex_valid, ex_is_br, ex_taken;
    logic [PW-1:0] ex_pc, ex_target;
    logic [PW-1:0] pc_check, redirect_pc;
    logic          is_br_check, br_taken_check, flush, order_err;
    logic [CW-1:0] br_count, mispred_count;

    int n_checks = 0;
    int n_fail   = 0;

    branch_resolve_unit #(
        .PC_WIDTH  (PW),
        .DEPTH     (4),
        .CNT_WIDTH (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .if_valid       (if_valid),
        .if_is_br       (if_is_br),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .if_stall       (if_stall),
        .ex_valid       (ex_valid),
        .ex_is_br       (ex_is_br),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .pc_check       (pc_check),
        .is_br_check    (is_br_check),
        .br_taken_check (br_taken_check),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .order_err      (order_err),
        .br_count       (br_count),
        .mispred_count  (mispred_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_valid = 0; if_is_br = 0; if_pc = '0; if_pred_taken = 0;
        ex_valid = 0; ex_is_br = 0; ex_pc = '0; ex_taken = 0; ex_target = '0;
    endtask

    task automatic drive_if(input logic [PW-1:0] pc, input logic pred);
        if_valid = 1; if_is_br = 1; if_pc = pc; if_pred_taken = pred;
    endtask

    task automatic drive_ex(input logic [PW-1:0] pc, input logic tk, input logic [PW-1:0] tgt);
        ex_valid = 1; ex_is_br = 1; ex_pc = pc; ex_taken = tk; ex_target = tgt;
    endtask

    task automatic clear_if();
        if_valid = 0; if_is_br = 0;
    endtask

    task automatic clear_ex();
        ex_valid = 0; ex_is_br = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        tick();
        n_checks++;
        if ({is_br_check, br_taken_check, flush, order_err, if_stall} !== 5'b0 ||
            pc_check !== '0 || redirect_pc !== '0 || br_count !== '0 || mispred_count !== '0) begin
            n_fail++;
            $display("FAIL reset_state: chk=%b tk=%b fl=%b oe=%b pc=%h rd=%h bc=%0d mc=%0d, want all 0",
                     is_br_check, br_taken_check, flush, order_err, pc_check, redirect_pc,
                     br_count, mispred_count);
        end
        reset = 0;
        tick();
    endtask

    task automatic test_correct();
        drive_if(32'h100, 1); tick(); clear_if();
        drive_ex(32'h100, 1, 32'h180); tick(); clear_ex();
        n_checks++;
        if (is_br_check !== 1 || pc_check !== 32'h100 || br_taken_check !== 1 || flush !== 0 ||
            br_count !== 1 || mispred_count !== 0 || order_err !== 0) begin
            n_fail++;
            $display("FAIL correct_pred: chk=%b pc=%h tk=%b fl=%b bc=%0d mc=%0d oe=%b, want 1 100 1 0 1 0 0",
                     is_br_check, pc_check, br_taken_check, flush, br_count, mispred_count, order_err);
        end
        tick();
        n_checks++;
        if (is_br_check !== 0 || pc_check !== '0) begin
            n_fail++;
            $display("FAIL check_idle: chk=%b pc=%h, want 0 0", is_br_check, pc_check);
        end
    endtask

    task automatic test_mispred_nt();
        drive_if(32'h200, 0); tick(); clear_if();
        drive_ex(32'h200, 1, 32'h240); tick(); clear_ex();
        n_checks++;
        if (flush !== 1 || redirect_pc !== 32'h240 || mispred_count !== 1 || br_count !== 2) begin
            n_fail++;
            $display("FAIL mispred_nt: fl=%b rd=%h mc=%0d bc=%0d, want 1 240 1 2",
                     flush, redirect_pc, mispred_count, br_count);
        end
        tick();
        n_checks++;
        if (flush !== 0 || redirect_pc !== 32'h240) begin
            n_fail++;
            $display("FAIL flush_one_cycle: fl=%b rd=%h, want 0 240", flush, redirect_pc);
        end
    endtask

    task automatic test_mispred_young();
        drive_if(32'h300, 1); tick();
        drive_if(32'h304, 0); tick();
        drive_if(32'h308, 0); tick();
        // Wrong-path enq in the same cycle as the mispredicting resolve.
        drive_if(32'h30C, 1);
        drive_ex(32'h300, 0, 32'h3F0); tick(); clear_ex();
        n_checks++;
        if (flush !== 1 || redirect_pc !== 32'h304 || mispred_count !== 2) begin
            n_fail++;
            $display("FAIL mispred_tn: fl=%b rd=%h mc=%0d, want 1 304 2", flush, redirect_pc, mispred_count);
        end
        // Enq during the flush cycle must be dropped.
        drive_if(32'h400, 1); tick();
        drive_if(32'h500, 0); tick(); clear_if();
        drive_ex(32'h500, 0, 32'h0); tick(); clear_ex();
        n_checks++;
        if (order_err !== 0 || flush !== 0 || pc_check !== 32'h500 || br_count !== 4) begin
            n_fail++;
            $display("FAIL after_flush_head: oe=%b fl=%b pc=%h bc=%0d, want 0 0 500 4",
                     order_err, flush, pc_check, br_count);
        end
    endtask

    task automatic test_full();
        logic [PW-1:0] pcs [8];
        logic          prd [8];
        int            flush_seen;
        for (int i = 0; i < 8; i++) begin
            pcs[i] = 32'h10 + 32'(4 * i);
            prd[i] = logic'(i % 2);
        end
        for (int i = 0; i < 4; i++) begin
            drive_if(pcs[i], prd[i]); tick();
        end
        drive_if(pcs[4], prd[4]); #1;
        n_checks++;
        if (if_stall !== 1) begin
            n_fail++;
            $display("FAIL full_stall: if_stall=%b, want 1", if_stall);
        end
        drive_ex(pcs[0], prd[0], 32'h0); #1;
        n_checks++;
        if (if_stall !== 0) begin
            n_fail++;
            $display("FAIL full_enq_deq: if_stall=%b, want 0", if_stall);
        end
        tick(); clear_ex();
        // Occupancy unchanged: still full.
        drive_if(pcs[5], prd[5]); #1;
        n_checks++;
        if (if_stall !== 1) begin
            n_fail++;
            $display("FAIL still_full: if_stall=%b, want 1", if_stall);
        end
        clear_if();
        flush_seen = 0;
        for (int i = 1; i < 5; i++) begin
            drive_ex(pcs[i], prd[i], 32'h0); tick();
            flush_seen += int'(flush);
            n_checks++;
            if (pc_check !== pcs[i] || br_taken_check !== prd[i]) begin
                n_fail++;
                $display("FAIL fifo_order_%0d: pc=%h tk=%b, want %h %b",
                         i, pc_check, br_taken_check, pcs[i], prd[i]);
            end
        end
        clear_ex();
        for (int i = 5; i < 8; i++) begin
            drive_if(pcs[i], prd[i]); tick();
        end
        clear_if();
        for (int i = 5; i < 8; i++) begin
            drive_ex(pcs[i], prd[i], 32'h0); tick();
            flush_seen += int'(flush);
            n_checks++;
            if (pc_check !== pcs[i] || br_taken_check !== prd[i]) begin
                n_fail++;
                $display("FAIL fifo_order_%0d: pc=%h tk=%b, want %h %b",
                         i, pc_check, br_taken_check, pcs[i], prd[i]);
            end
        end
        clear_ex();
        n_checks++;
        if (flush_seen != 0 || order_err !== 0 || br_count !== 12 || mispred_count !== 2) begin
            n_fail++;
            $display("FAIL full_summary: flushes=%0d oe=%b bc=%0d mc=%0d, want 0 0 12 2",
                     flush_seen, order_err, br_count, mispred_count);
        end
    endtask

    task automatic test_errors();
        drive_ex(32'h600, 1, 32'h700); tick(); clear_ex();
        n_checks++;
        if (order_err !== 1 || flush !== 1 || redirect_pc !== 32'h700 || pc_check !== 32'h600 ||
            br_count !== 13 || mispred_count !== 3) begin
            n_fail++;
            $display("FAIL empty_resolve: oe=%b fl=%b rd=%h pc=%h bc=%0d mc=%0d, want 1 1 700 600 13 3",
                     order_err, flush, redirect_pc, pc_check, br_count, mispred_count);
        end
        tick(); tick();
        n_checks++;
        if (order_err !== 1) begin
            n_fail++;
            $display("FAIL order_err_sticky: oe=%b, want 1", order_err);
        end
        reset = 1; tick(); reset = 0; tick();
        n_checks++;
        if (order_err !== 0) begin
            n_fail++;
            $display("FAIL order_err_reset: oe=%b, want 0", order_err);
        end
        drive_if(32'h800, 1); tick(); clear_if();
        drive_ex(32'h804, 1, 32'h900); tick(); clear_ex();
        n_checks++;
        if (order_err !== 1 || flush !== 0 || br_count !== 1 || mispred_count !== 0) begin
            n_fail++;
            $display("FAIL pc_mismatch: oe=%b fl=%b bc=%0d mc=%0d, want 1 0 1 0",
                     order_err, flush, br_count, mispred_count);
        end
        // Empty queue, actual not-taken: agrees with the implied not-taken.
        drive_ex(32'hA00, 0, 32'hB00); tick(); clear_ex();
        n_checks++;
        if (flush !== 0 || order_err !== 1 || br_count !== 2 || mispred_count !== 0) begin
            n_fail++;
            $display("FAIL empty_nt: fl=%b oe=%b bc=%0d mc=%0d, want 0 1 2 0",
                     flush, order_err, br_count, mispred_count);
        end
    endtask

    task automatic test_async_reset();
        drive_if(32'h900, 0); tick();
        drive_if(32'h904, 0); tick();
        drive_if(32'h908, 0); tick(); clear_if();
        drive_ex(32'h900, 1, 32'h9F0);
        #2;
        reset = 1;
        #1;
        n_checks++;
        if (order_err !== 0 || br_count !== '0 || mispred_count !== '0 || flush !== 0 ||
            is_br_check !== 0 || pc_check !== '0 || redirect_pc !== '0) begin
            n_fail++;
            $display("FAIL async_reset: oe=%b bc=%0d mc=%0d fl=%b chk=%b pc=%h rd=%h, want all 0",
                     order_err, br_count, mispred_count, flush, is_br_check, pc_check, redirect_pc);
        end
        idle();
        tick();
        #2;
        reset = 0;
        tick();
        n_checks++;
        if (flush !== 0 || is_br_check !== 0 || redirect_pc !== '0) begin
            n_fail++;
            $display("FAIL post_reset_flush: fl=%b chk=%b rd=%h, want 0 0 0", flush, is_br_check, redirect_pc);
        end
        // Queue must be empty: a resolve now reports an ordering error.
        drive_ex(32'h900, 0, 32'h0); tick(); clear_ex();
        n_checks++;
        if (order_err !== 1 || flush !== 0) begin
            n_fail++;
            $display("FAIL post_reset_empty: oe=%b fl=%b, want 1 0", order_err, flush);
        end
    endtask

    initial begin
        reset = 0;
        idle();
        test_reset();
        test_correct();
        test_mispred_nt();
        test_mispred_young();
        test_full();
        test_errors();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
